// File: rtl/cache_2wsa_ctrl.sv
// Control FSM for a 2-way set-associative cache.
// Holds the tag/valid/dirty/LRU state, performs tag compare, and sequences the
// external data array plus the dirty-victim writeback and the line fill to memory.
module cache_2wsa_ctrl #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned IDX_W  = 3,
    parameter int unsigned OFF_W  = 2
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [ADDR_W-1:0] i_addr_cpu,
    input  logic              i_rd_cpu,
    input  logic              i_wr_cpu,
    output logic              o_stall_cpu,
    output logic              o_data_oe_cpu,
    output logic [ADDR_W-1:0] o_addr_mem,
    output logic              o_rd_mem,
    output logic              o_wr_mem,
    input  logic              i_ready_mem,
    output logic              o_da_we,
    output logic              o_da_sel_mem,
    output logic              o_da_way,
    output logic [IDX_W-1:0]  o_da_index,
    output logic [OFF_W-1:0]  o_da_offset
);

    localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned SETS  = 1 << IDX_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_WB      = 2'd2,
        S_FILL    = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wr;
    logic [OFF_W-1:0]  r_beat;
    logic              r_victim;
    logic [TAG_W-1:0]  r_tag   [2][SETS];
    logic [SETS-1:0]   r_valid [2];
    logic [SETS-1:0]   r_dirty [2];
    logic [SETS-1:0]   r_lru;

    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_idx;
    logic [OFF_W-1:0]  w_off;
    logic              w_req;
    logic              w_hit0;
    logic              w_hit1;
    logic              w_hit;
    logic              w_hit_way;
    logic              w_miss_victim;
    logic              w_victim_dirty;
    logic              w_last;

    // Address fields, tag compare and victim choice, all from the latched address
    assign w_tag          = r_addr[ADDR_W-1 -: TAG_W];
    assign w_idx          = r_addr[OFF_W +: IDX_W];
    assign w_off          = r_addr[OFF_W-1:0];
    assign w_req          = i_rd_cpu | i_wr_cpu;
    assign w_hit0         = r_valid[0][w_idx] & (r_tag[0][w_idx] == w_tag);
    assign w_hit1         = r_valid[1][w_idx] & (r_tag[1][w_idx] == w_tag);
    assign w_hit          = w_hit0 | w_hit1;
    assign w_hit_way      = ~w_hit0;
    assign w_miss_victim  = ~r_valid[0][w_idx] ? 1'b0 :
                            (~r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx]);
    assign w_victim_dirty = r_valid[w_miss_victim][w_idx] & r_dirty[w_miss_victim][w_idx];
    assign w_last         = (r_beat == {OFF_W{1'b1}});

    // Stall until the cycle in which COMPARE sees a hit
    assign o_stall_cpu = w_req & ~((r_state == S_COMPARE) & w_hit);

    // State machine and cache bookkeeping; tags need no reset because valid gates them
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_wr       <= 1'b0;
            r_beat     <= '0;
            r_victim   <= 1'b0;
            r_valid[0] <= '0;
            r_valid[1] <= '0;
            r_dirty[0] <= '0;
            r_dirty[1] <= '0;
            r_lru      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr  <= i_addr_cpu;
                        r_wr    <= i_wr_cpu;
                        r_state <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (!w_req) begin
                        r_state <= S_IDLE;
                    end else if (w_hit) begin
                        r_lru[w_idx] <= ~w_hit_way;
                        if (r_wr) begin
                            r_dirty[w_hit_way][w_idx] <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_victim <= w_miss_victim;
                        r_state  <= w_victim_dirty ? S_WB : S_FILL;
                    end
                end
                S_WB: begin
                    if (i_ready_mem) begin
                        r_beat <= w_last ? '0 : r_beat + OFF_W'(1);
                        if (w_last) begin
                            r_dirty[r_victim][w_idx] <= 1'b0;
                            r_state                  <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (i_ready_mem) begin
                        r_beat <= w_last ? '0 : r_beat + OFF_W'(1);
                        if (w_last) begin
                            r_tag[r_victim][w_idx]   <= w_tag;
                            r_valid[r_victim][w_idx] <= 1'b1;
                            r_dirty[r_victim][w_idx] <= 1'b0;
                            r_state                  <= S_COMPARE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Array and memory strobes decoded from the current state and beat
    always_comb begin
        o_data_oe_cpu = 1'b0;
        o_addr_mem    = '0;
        o_rd_mem      = 1'b0;
        o_wr_mem      = 1'b0;
        o_da_we       = 1'b0;
        o_da_sel_mem  = 1'b0;
        o_da_way      = 1'b0;
        o_da_index    = '0;
        o_da_offset   = '0;
        case (r_state)
            S_COMPARE: begin
                if (w_req && w_hit) begin
                    o_da_way    = w_hit_way;
                    o_da_index  = w_idx;
                    o_da_offset = w_off;
                    if (r_wr) begin
                        o_da_we = 1'b1;
                    end else begin
                        o_data_oe_cpu = 1'b1;
                    end
                end
            end
            S_WB: begin
                o_wr_mem    = 1'b1;
                o_addr_mem  = {r_tag[r_victim][w_idx], w_idx, r_beat};
                o_da_way    = r_victim;
                o_da_index  = w_idx;
                o_da_offset = r_beat;
            end
            S_FILL: begin
                o_rd_mem    = 1'b1;
                o_addr_mem  = {w_tag, w_idx, r_beat};
                o_da_way    = r_victim;
                o_da_index  = w_idx;
                o_da_offset = r_beat;
                if (i_ready_mem) begin
                    o_da_we      = 1'b1;
                    o_da_sel_mem = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_2wsa_ctrl.sv
// Directed testbench for cache_2wsa_ctrl: hit, clean miss, dirty miss,
// memory wait states, reset abort and read+write priority.
module tb_cache_2wsa_ctrl;

    logic       clk = 1'b0;
    logic       i_reset;
    logic [8:0] i_addr_cpu;
    logic       i_rd_cpu;
    logic       i_wr_cpu;
    logic       i_ready_mem;
    logic       o_stall_cpu;
    logic       o_data_oe_cpu;
    logic [8:0] o_addr_mem;
    logic       o_rd_mem;
    logic       o_wr_mem;
    logic       o_da_we;
    logic       o_da_sel_mem;
    logic       o_da_way;
    logic [2:0] o_da_index;
    logic [1:0] o_da_offset;

    int n_cmp = 0;
    int n_err = 0;

    // Results of the most recent transaction
    int         lat;
    int         both_cnt;
    int         oe_cnt;
    int         fill_err;
    int         hold_err;
    logic [8:0] rd_q[$];
    logic [8:0] wr_q[$];
    logic       fin_we;
    logic       fin_sel;
    logic       fin_way;
    logic [1:0] fin_off;
    logic [2:0] fin_idx;

    always #5 clk = ~clk;

    cache_2wsa_ctrl dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_addr_cpu   (i_addr_cpu),
        .i_rd_cpu     (i_rd_cpu),
        .i_wr_cpu     (i_wr_cpu),
        .o_stall_cpu  (o_stall_cpu),
        .o_data_oe_cpu(o_data_oe_cpu),
        .o_addr_mem   (o_addr_mem),
        .o_rd_mem     (o_rd_mem),
        .o_wr_mem     (o_wr_mem),
        .i_ready_mem  (i_ready_mem),
        .o_da_we      (o_da_we),
        .o_da_sel_mem (o_da_sel_mem),
        .o_da_way     (o_da_way),
        .o_da_index   (o_da_index),
        .o_da_offset  (o_da_offset)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Hold a request until stall drops (bounded), logging memory beats and strobes
    task automatic txn(input logic [8:0] a, input logic rd, input logic wr, input bit toggle);
        logic       prev_wait;
        logic [8:0] prev_addr;
        lat = 0; both_cnt = 0; oe_cnt = 0; fill_err = 0; hold_err = 0;
        rd_q.delete(); wr_q.delete();
        fin_we = 1'b0; fin_sel = 1'b0; fin_way = 1'b0; fin_off = '0; fin_idx = '0;
        prev_wait = 1'b0; prev_addr = '0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            i_addr_cpu  = a;
            i_rd_cpu    = rd;
            i_wr_cpu    = wr;
            i_ready_mem = toggle ? ((c % 2) == 0) : 1'b1;
            #1;
            if (o_rd_mem && o_wr_mem) both_cnt++;
            if (o_data_oe_cpu) oe_cnt++;
            if (prev_wait && (o_addr_mem !== prev_addr)) hold_err++;
            prev_wait = (o_rd_mem || o_wr_mem) && !i_ready_mem;
            prev_addr = o_addr_mem;
            if (o_rd_mem && i_ready_mem) begin
                rd_q.push_back(o_addr_mem);
                if (!(o_da_we && o_da_sel_mem)) fill_err++;
            end
            if (o_wr_mem && i_ready_mem) wr_q.push_back(o_addr_mem);
            if (!o_stall_cpu) begin
                lat     = c;
                fin_we  = o_da_we;
                fin_sel = o_da_sel_mem;
                fin_way = o_da_way;
                fin_off = o_da_offset;
                fin_idx = o_da_index;
                break;
            end
        end
        @(posedge clk); #1;
        i_rd_cpu    = 1'b0;
        i_wr_cpu    = 1'b0;
        i_ready_mem = 1'b1;
    endtask

    task automatic chk_txn(input string t, input int exp_lat, input int exp_oe,
                           input logic exp_we, input logic exp_way,
                           input logic [8:0] wr_base, input int n_wr,
                           input logic [8:0] rd_base, input int n_rd);
        chk({t, " latency"}, 32'(lat), 32'(exp_lat));
        chk({t, " oe cycles"}, 32'(oe_cnt), 32'(exp_oe));
        chk({t, " final we"}, 32'(fin_we), 32'(exp_we));
        chk({t, " final way"}, 32'(fin_way), 32'(exp_way));
        chk({t, " rd&wr overlap"}, 32'(both_cnt), 32'(0));
        chk({t, " fill we/sel"}, 32'(fill_err), 32'(0));
        chk({t, " addr hold"}, 32'(hold_err), 32'(0));
        chk({t, " wr beats"}, 32'(wr_q.size()), 32'(n_wr));
        for (int i = 0; i < wr_q.size() && i < n_wr; i++)
            chk({t, " wr addr"}, 32'(wr_q[i]), 32'(wr_base) + 32'(i));
        chk({t, " rd beats"}, 32'(rd_q.size()), 32'(n_rd));
        for (int i = 0; i < rd_q.size() && i < n_rd; i++)
            chk({t, " rd addr"}, 32'(rd_q[i]), 32'(rd_base) + 32'(i));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1; i_addr_cpu = '0; i_rd_cpu = 1'b0; i_wr_cpu = 1'b0; i_ready_mem = 1'b0;

        // Reset: everything quiet, stall tracks a request
        repeat (4) @(posedge clk);
        #2;
        chk("reset stall", 32'(o_stall_cpu), 32'(0));
        chk("reset rd_mem", 32'(o_rd_mem), 32'(0));
        chk("reset wr_mem", 32'(o_wr_mem), 32'(0));
        chk("reset da_we", 32'(o_da_we), 32'(0));
        chk("reset oe", 32'(o_data_oe_cpu), 32'(0));
        chk("reset addr_mem", 32'(o_addr_mem), 32'(0));
        i_rd_cpu = 1'b1; #1;
        chk("reset stall req", 32'(o_stall_cpu), 32'(1));
        i_rd_cpu = 1'b0; i_reset = 1'b0; i_ready_mem = 1'b1;

        // 1: write miss, clean fill into way 0, write on completion
        txn(9'h007, 1'b0, 1'b1, 1'b0);
        chk_txn("t1", 7, 0, 1'b1, 1'b0, 9'h000, 0, 9'h004, 4);
        chk("t1 final sel", 32'(fin_sel), 32'(0));
        chk("t1 final off", 32'(fin_off), 32'(3));
        chk("t1 final idx", 32'(fin_idx), 32'(1));

        // 2: read hit
        txn(9'h007, 1'b1, 1'b0, 1'b0);
        chk_txn("t2", 2, 1, 1'b0, 1'b0, 9'h000, 0, 9'h000, 0);

        // 3: clean miss into empty way 1
        txn(9'h027, 1'b1, 1'b0, 1'b0);
        chk_txn("t3", 7, 1, 1'b0, 1'b1, 9'h000, 0, 9'h024, 4);

        // 4: dirty LRU victim way 0: writeback then fill
        txn(9'h047, 1'b1, 1'b0, 1'b0);
        chk_txn("t4", 11, 1, 1'b0, 1'b0, 9'h004, 4, 9'h044, 4);

        // 5: dirty way 0 again, make it LRU, then dirty miss with ready toggling
        txn(9'h047, 1'b0, 1'b1, 1'b0);
        chk_txn("t5 wr hit", 2, 0, 1'b1, 1'b0, 9'h000, 0, 9'h000, 0);
        txn(9'h027, 1'b1, 1'b0, 1'b0);
        chk_txn("t5 rd hit", 2, 1, 1'b0, 1'b1, 9'h000, 0, 9'h000, 0);
        txn(9'h007, 1'b1, 1'b0, 1'b1);
        chk_txn("t5 slow", 19, 1, 1'b0, 1'b0, 9'h044, 4, 9'h004, 4);

        // 6: reset during fill beat 2
        @(posedge clk); #1;
        i_addr_cpu = 9'h0A3; i_rd_cpu = 1'b1; i_ready_mem = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk("t6 beat2 rd_mem", 32'(o_rd_mem), 32'(1));
        chk("t6 beat2 addr", 32'(o_addr_mem), 32'h0A2);
        i_reset = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0;
        #1;
        chk("t6 post-reset rd_mem", 32'(o_rd_mem), 32'(0));
        chk("t6 post-reset wr_mem", 32'(o_wr_mem), 32'(0));
        chk("t6 post-reset da_we", 32'(o_da_we), 32'(0));
        chk("t6 post-reset stall", 32'(o_stall_cpu), 32'(1));
        i_rd_cpu = 1'b0;

        txn(9'h0A3, 1'b1, 1'b0, 1'b0);
        chk_txn("t6 re-miss", 7, 1, 1'b0, 1'b0, 9'h000, 0, 9'h0A0, 4);

        // Read and write together on a hit: write wins
        txn(9'h0A3, 1'b1, 1'b1, 1'b0);
        chk_txn("t6 rdwr hit", 2, 0, 1'b1, 1'b0, 9'h000, 0, 9'h000, 0);
        chk("t6 rdwr sel", 32'(fin_sel), 32'(0));

        // Fill way 1, then the dirty way 0 must be written back
        txn(9'h0C3, 1'b1, 1'b0, 1'b0);
        chk_txn("t6 fill w1", 7, 1, 1'b0, 1'b1, 9'h000, 0, 9'h0C0, 4);
        txn(9'h0E3, 1'b1, 1'b0, 1'b0);
        chk_txn("t6 dirty evict", 11, 1, 1'b0, 1'b0, 9'h0A0, 4, 9'h0E0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
